// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, flag bit positions and FSM encoding for the alu issue controller
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_CNT_W  = 16;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_flag_reg.sv
// rtl/alu_flag_reg.sv - architectural {V,N,Z,C} flag register with update-over-clear priority
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_upd,
    input  logic [3:0] i_flags,
    output logic [3:0] o_flags
);

    logic [3:0] r_flags;

    // An ALU write-back in the same cycle as a clear keeps the fresh flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (i_upd) begin
            r_flags <= i_flags;
        end else if (i_clr) begin
            r_flags <= 4'b0000;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one command to the combinational alu, captures result/flags, returns a response
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int CNT_W  = ALU_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_upd,
    input  logic              flag_clr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  op_count,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [3:0]        alu_s_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_s_c,
    input  logic              alu_s_z,
    input  logic              alu_s_n,
    input  logic              alu_s_v
);

    issue_state_t r_state;
    issue_state_t w_next_state;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [3:0]        r_alu_s_in;
    logic              r_upd;
    logic [DATA_W-1:0] r_rsp_result;
    logic [3:0]        r_rsp_flags;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_accept;
    logic              w_capture;
    logic              w_retire;
    logic              w_flag_upd;
    logic [3:0]        w_alu_flags;
    logic [3:0]        w_flags_q;

    // Pack the alu flag outputs into the {V,N,Z,C} order used everywhere.
    always_comb begin
        w_alu_flags        = 4'b0000;
        w_alu_flags[FLG_C] = alu_s_c;
        w_alu_flags[FLG_Z] = alu_s_z;
        w_alu_flags[FLG_N] = alu_s_n;
        w_alu_flags[FLG_V] = alu_s_v;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake strobes; EXEC always lasts exactly one settle cycle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_capture    = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand registers only load on acceptance so the alu inputs never change mid-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_alu_s_in <= 4'b0000;
            r_upd      <= 1'b0;
        end else if (w_accept) begin
            r_alu_a    <= cmd_a;
            r_alu_b    <= cmd_b;
            r_alu_op   <= cmd_op;
            r_alu_s_in <= w_flags_q;
            r_upd      <= cmd_upd;
        end
    end

    // Response capture after the alu has had one full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else if (w_capture) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= w_alu_flags;
        end
    end

    // Completed-response counter, sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_retire && (r_op_count != {CNT_W{1'b1}})) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign w_flag_upd = w_capture && r_upd;

    alu_flag_reg u_flag_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (flag_clr),
        .i_upd   (w_flag_upd),
        .i_flags (w_alu_flags),
        .o_flags (w_flags_q)
    );

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign flags_q    = w_flags_q;
    assign op_count   = r_op_count;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_s_in   = r_alu_s_in;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with an adder stub alu
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_upd;
    logic        flag_clr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags_q;
    logic [15:0] op_count;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [3:0]  alu_s_in;
    logic [7:0]  alu_result;
    logic        alu_s_c;
    logic        alu_s_z;
    logic        alu_s_n;
    logic        alu_s_v;

    logic [8:0]  stub_sum;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_upd    (cmd_upd),
        .flag_clr   (flag_clr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flags_q    (flags_q),
        .op_count   (op_count),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_s_in   (alu_s_in),
        .alu_result (alu_result),
        .alu_s_c    (alu_s_c),
        .alu_s_z    (alu_s_z),
        .alu_s_n    (alu_s_n),
        .alu_s_v    (alu_s_v)
    );

    // Stub alu: add, carry, zero, negative, signed overflow; opcode ignored.
    assign stub_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = stub_sum[7:0];
    assign alu_s_c    = stub_sum[8];
    assign alu_s_z    = (stub_sum[7:0] == 8'd0);
    assign alu_s_n    = stub_sum[7];
    assign alu_s_v    = (alu_a[7] == alu_b[7]) && (stub_sum[7] != alu_a[7]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on handshake, checks hold stability while the consumer stalls.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got result 0x%0h with empty scoreboard", rsp_result);
            end else begin
                chk("rsp_result", {24'd0, rsp_result}, {24'd0, exp_q[0][11:4]});
                chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, exp_q[0][3:0]});
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic upd, input logic [7:0] exp_res, input logic [3:0] exp_flg);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_upd   = upd;
        cmd_valid = 1'b1;
        exp_q.push_back({exp_res, exp_flg});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_upd   = 1'b0;
        flag_clr  = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_flags_q", {28'd0, flags_q}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // 0 + 1, op 10, latency and counter
        send(8'd0, 8'd1, 4'd10, 1'b1, 8'd1, 4'b0000);
        chk("t2_alu_op", {28'd0, alu_op}, 32'd10);
        @(negedge clk);
        chk("t2_exec_no_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t2_resp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("t2_op_count", {16'd0, op_count}, 32'd1);
        chk("t2_flags_q", {28'd0, flags_q}, 32'd0);

        // 220 + 100 carries out; next command sees the snapshot
        send(8'd220, 8'd100, 4'd0, 1'b1, 8'd64, 4'b0001);
        repeat (3) @(negedge clk);
        chk("t3_flags_q", {28'd0, flags_q}, 32'h1);
        chk("t3_op_count", {16'd0, op_count}, 32'd2);
        send(8'd5, 8'd6, 4'd1, 1'b0, 8'd11, 4'b0000);
        chk("t3_alu_s_in", {28'd0, alu_s_in}, 32'h1);
        chk("t3_alu_a", {24'd0, alu_a}, 32'd5);
        repeat (3) @(negedge clk);
        chk("t3_flags_kept", {28'd0, flags_q}, 32'h1);

        // -120 + -100 overflows, consumer stalls five cycles, stray cmd_valid ignored
        rsp_ready = 1'b0;
        send(8'd136, 8'd156, 4'd3, 1'b0, 8'd36, 4'b1001);
        @(negedge clk);
        cmd_a     = 8'd77;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("t4_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("t4_alu_a_stable", {24'd0, alu_a}, 32'd136);
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_flags_unchanged", {28'd0, flags_q}, 32'h1);
        chk("t4_op_count", {16'd0, op_count}, 32'd4);

        // Clear colliding with an EXEC update: update wins; snapshot unaffected
        send(8'd0, 8'd0, 4'd0, 1'b1, 8'd0, 4'b0010);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        @(negedge clk);
        chk("t5_update_wins", {28'd0, flags_q}, 32'h2);
        chk("t5_snapshot", {28'd0, alu_s_in}, 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1;
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_alone", {28'd0, flags_q}, 32'h0);

        // Reset dropped in EXEC aborts the op
        send(8'd3, 8'd4, 4'd0, 1'b1, 8'd7, 4'b0000);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("t6_flags_q", {28'd0, flags_q}, 32'd0);
        chk("t6_op_count", {16'd0, op_count}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd100, 8'd100, 4'd0, 1'b1, 8'd200, 4'b1100);
        repeat (3) @(negedge clk);
        chk("t6_recover_count", {16'd0, op_count}, 32'd1);
        chk("t6_recover_flags", {28'd0, flags_q}, 32'hC);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
